// File: rtl/single_port_ram_p.sv
// Single-port synchronous RAM: byte-enable writes, selectable read-during-write, zero-fill sequencer.
// Optional macro SPRAM_OUTREG_EN adds one output register stage on q/q_valid (read latency 2).
module single_port_ram_p #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 6,
   parameter int unsigned RDW_MODE = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     data,
   input  logic [DATA_W/8-1:0]   be,
   output logic                  ready,
   output logic                  init_busy,
   output logic [DATA_W-1:0]     q,
   output logic                  q_valid
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned BE_W  = DATA_W / 8;

   typedef enum logic {INIT, RUN} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   cnt;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   rd_word;
   logic [DATA_W-1:0]   merged;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   q_r;
   logic                qv_r;

   assign rd_word = mem[addr];

   // Byte-lane merge of write data over the currently stored word
   always_comb begin
      merged = rd_word;
      for (int i = 0; i < int'(BE_W); i++) begin
         if (be[i]) merged[8*i +: 8] = data[8*i +: 8];
      end
   end

   // Array port arbitration: fill sequencer owns the port in INIT
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = addr;
      mem_wdata = merged;
      if (state == INIT) begin
         if (!clr) begin
            mem_we    = 1'b1;
            mem_addr  = cnt;
            mem_wdata = '0;
         end
      end else if (req && we && !clr) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT;
         cnt       <= '0;
         q_r       <= '0;
         qv_r      <= 1'b0;
         ready     <= 1'b0;
         init_busy <= 1'b1;
      end else begin
         qv_r <= 1'b0;
         if (state == INIT) begin
            if (clr) begin
               cnt <= '0;
            end else begin
               cnt <= cnt + ADDR_W'(1);
               if (cnt == ADDR_W'(DEPTH - 1)) begin
                  state     <= RUN;
                  ready     <= 1'b1;
                  init_busy <= 1'b0;
               end
            end
         end else begin
            if (clr) begin
               state     <= INIT;
               cnt       <= '0;
               ready     <= 1'b0;
               init_busy <= 1'b1;
            end else if (req) begin
               if (!we) begin
                  q_r  <= rd_word;
                  qv_r <= 1'b1;
               end else if (RDW_MODE == 0) begin
                  q_r  <= merged;
                  qv_r <= 1'b1;
               end else if (RDW_MODE == 1) begin
                  q_r  <= rd_word;
                  qv_r <= 1'b1;
               end
            end
         end
      end
   end

`ifdef SPRAM_OUTREG_EN
   logic [DATA_W-1:0] q_o;
   logic              qv_o;

   // Extra output stage; a pending strobe is dropped when clr arrives
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_o  <= '0;
         qv_o <= 1'b0;
      end else begin
         q_o  <= q_r;
         qv_o <= qv_r && !clr;
      end
   end

   assign q       = q_o;
   assign q_valid = qv_o;
`else
   assign q       = q_r;
   assign q_valid = qv_r;
`endif

endmodule

// File: tb/tb_single_port_ram_p.sv
// Scoreboard bench for single_port_ram_p: write-first/read-first/no-change 8-bit instances and a 32-bit instance.
module tb_single_port_ram_p;

`ifdef SPRAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      logic [31:0] v;
      int          c;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, clr, req, we, b;
   logic [5:0]  addr;
   logic [7:0]  data;
   logic        clr3, req3, we3;
   logic [5:0]  addr3;
   logic [31:0] data3;
   logic [3:0]  be3;

   logic        rdy0, rdy1, rdy2, rdy3, ib0, ib1, ib2, ib3, qv0, qv1, qv2, qv3;
   logic [7:0]  q0, q1, q2;
   logic [31:0] q3;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb0[$], sb1[$], sb2[$], sb3[$];
   logic [7:0]  m8  [64];
   logic [31:0] m32 [64];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   single_port_ram_p #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .we(we), .addr(addr), .data(data), .be(b),
      .ready(rdy0), .init_busy(ib0), .q(q0), .q_valid(qv0));
   single_port_ram_p #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .we(we), .addr(addr), .data(data), .be(b),
      .ready(rdy1), .init_busy(ib1), .q(q1), .q_valid(qv1));
   single_port_ram_p #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .we(we), .addr(addr), .data(data), .be(b),
      .ready(rdy2), .init_busy(ib2), .q(q2), .q_valid(qv2));
   single_port_ram_p #(.DATA_W(32), .ADDR_W(6), .RDW_MODE(0)) dut3 (
      .clk(clk), .rst_n(rst_n), .clr(clr3), .req(req3), .we(we3), .addr(addr3), .data(data3), .be(be3),
      .ready(rdy3), .init_busy(ib3), .q(q3), .q_valid(qv3));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input int id, input logic [31:0] obs);
      exp_t e;
      int   sz;
      case (id)
         0: sz = sb0.size();
         1: sz = sb1.size();
         2: sz = sb2.size();
         default: sz = sb3.size();
      endcase
      if (sz == 0) begin
         checks++;
         errors++;
         $error("FAIL unexpected_qv%0d observed=%h expected=no_strobe", id, obs);
      end else begin
         case (id)
            0: e = sb0.pop_front();
            1: e = sb1.pop_front();
            2: e = sb2.pop_front();
            default: e = sb3.pop_front();
         endcase
         check($sformatf("q_dut%0d", id), obs, e.v);
         check($sformatf("lat_dut%0d", id), 32'(cyc - e.c), 32'(LAT));
      end
   endtask

   // Output monitor: every strobe must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n) begin
         if (qv0) pop_chk(0, 32'(q0));
         if (qv1) pop_chk(1, 32'(q1));
         if (qv2) pop_chk(2, 32'(q2));
         if (qv3) pop_chk(3, q3);
      end
   end

   task automatic model_clear();
      for (int i = 0; i < 64; i++) m8[i] = 8'h00;
   endtask

   task automatic acc(input logic w, input logic [5:0] a, input logic [7:0] d, input logic be_i);
      logic [7:0] old, mrg;
      old = m8[a];
      mrg = be_i ? d : old;
      if (w) begin
         sb0.push_back('{32'(mrg), cyc});
         sb1.push_back('{32'(old), cyc});
         m8[a] = mrg;
      end else begin
         sb0.push_back('{32'(old), cyc});
         sb1.push_back('{32'(old), cyc});
         sb2.push_back('{32'(old), cyc});
      end
      req = 1'b1; we = w; addr = a; data = d; b = be_i;
      @(posedge clk); #1;
      req = 1'b0; we = 1'b0;
   endtask

   task automatic acc32(input logic w, input logic [5:0] a, input logic [31:0] d, input logic [3:0] be_i);
      logic [31:0] mrg;
      mrg = m32[a];
      for (int i = 0; i < 4; i++) if (be_i[i]) mrg[8*i +: 8] = d[8*i +: 8];
      sb3.push_back('{w ? mrg : m32[a], cyc});
      if (w) m32[a] = mrg;
      req3 = 1'b1; we3 = w; addr3 = a; data3 = d; be3 = be_i;
      @(posedge clk); #1;
      req3 = 1'b0; we3 = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input int exp_edges, input string tag);
      int n = 0;
      while (!rdy0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check(tag, 32'(n), 32'(exp_edges));
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; req = 1'b0; we = 1'b0; addr = '0; data = '0; b = 1'b0;
      clr3 = 1'b0; req3 = 1'b0; we3 = 1'b0; addr3 = '0; data3 = '0; be3 = '0;
      model_clear();
      for (int i = 0; i < 64; i++) m32[i] = 32'h0;

      idle(3);
      check("rst_ready", 32'(rdy0), 32'd0);
      check("rst_init_busy", 32'(ib0), 32'd1);
      check("rst_q", 32'(q0), 32'd0);
      check("rst_q_valid", 32'(qv0), 32'd0);

      @(negedge clk); rst_n = 1'b1;
      wait_ready(64, "init_len");
      check("init_busy_low", 32'(ib0), 32'd0);
      check("ready_w32", 32'(rdy3), 32'd1);

      // Zero-fill readback of every address
      for (int i = 0; i < 64; i++) acc(1'b0, 6'(i), 8'h00, 1'b0);

      acc(1'b1, 6'd0, 8'h01, 1'b1);
      acc(1'b1, 6'd1, 8'h02, 1'b1);
      acc(1'b1, 6'd2, 8'h03, 1'b1);
      acc(1'b0, 6'd0, 8'h00, 1'b0);
      acc(1'b0, 6'd1, 8'h00, 1'b0);
      acc(1'b0, 6'd2, 8'h00, 1'b0);
      idle(3);

      // Read-during-write over 8'h02
      acc(1'b1, 6'd1, 8'h04, 1'b1);
      idle(3);
      check("rdw2_q_hold", 32'(q2), 32'h03);
      acc(1'b0, 6'd1, 8'h00, 1'b0);

      // be=0 write is accepted but changes nothing
      acc(1'b1, 6'd0, 8'hFF, 1'b0);
      acc(1'b0, 6'd0, 8'h00, 1'b0);

      acc32(1'b1, 6'd5, 32'hAABBCCDD, 4'hF);
      acc32(1'b1, 6'd5, 32'h11223344, 4'b0101);
      acc32(1'b0, 6'd5, 32'h0, 4'h0);
      check("w32_model", m32[5], 32'hAA22CC44);

      acc(1'b1, 6'd7, 8'h5A, 1'b1);
      acc(1'b0, 6'd7, 8'h00, 1'b0);
      idle(3);

      // clr with a simultaneous request: the request is dropped
      clr = 1'b1; req = 1'b1; we = 1'b1; addr = 6'd4; data = 8'h77; b = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0; req = 1'b0; we = 1'b0;
      model_clear();
      check("clr_ready", 32'(rdy0), 32'd0);
      check("clr_init_busy", 32'(ib0), 32'd1);
      idle(10);
      req = 1'b1; we = 1'b1; addr = 6'd3; data = 8'h55; b = 1'b1;
      @(posedge clk); #1;
      req = 1'b0; we = 1'b0;
      wait_ready(53, "clr_init_len");
      acc(1'b0, 6'd0, 8'h00, 1'b0);
      acc(1'b0, 6'd3, 8'h00, 1'b0);
      acc(1'b0, 6'd7, 8'h00, 1'b0);

      acc(1'b1, 6'd7, 8'h5A, 1'b1);
      acc(1'b0, 6'd7, 8'h00, 1'b0);
      idle(3);

      // Reset asserted at fill count 30
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      model_clear();
      idle(30);
      check("init_q_hold", 32'(q0), 32'h5A);
      check("init_ready", 32'(rdy0), 32'd0);
      rst_n = 1'b0;
      #1;
      check("midrst_q", 32'(q0), 32'd0);
      check("midrst_q_valid", 32'(qv0), 32'd0);
      check("midrst_ready", 32'(rdy0), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      wait_ready(64, "reinit_len");
      acc(1'b0, 6'd7, 8'h00, 1'b0);
      idle(5);

      check("drain_sb0", 32'(sb0.size()), 32'd0);
      check("drain_sb1", 32'(sb1.size()), 32'd0);
      check("drain_sb2", 32'(sb2.size()), 32'd0);
      check("drain_sb3", 32'(sb3.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
